// File: rtl/encoder_pkg.sv
// Shared encoder datapath constants and sequencer state encoding.
// Q10.10 word format used between layer buffers.
package encoder_pkg;

  localparam int DATA_W = 20;
  localparam int INT_W  = 10;
  localparam int FRAC_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WAIT_SINK,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  function automatic logic is_busy(
    input seq_state_t s
  );
    return !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
  endfunction

endpackage

// File: rtl/layer_transfer_sequencer_if.sv
// Source-buffer read port and sink-layer write port of a layer transfer.
// master = sequencer side, slave = buffer/sink side.
interface layer_transfer_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = encoder_pkg::DATA_W
);

  logic [ADDR_W-1:0] src_addr;
  logic              src_en;
  logic [DATA_W-1:0] src_data;
  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_done;

  modport master (
    output src_addr,
    output src_en,
    input  src_data,
    output snk_data,
    output snk_valid,
    input  snk_done
  );

  modport slave (
    input  src_addr,
    input  src_en,
    output src_data,
    input  snk_data,
    input  snk_valid,
    output snk_done
  );

endinterface

// File: rtl/valid_delay_line.sv
// Shift line tracking in-flight reads; out aligns with read data.
// empty is high when no issued read is still pending.
module valid_delay_line #(
  parameter int DEPTH = 2
)(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic empty
);

  logic [DEPTH-1:0] sr;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sr <= '0;
      else        sr <= in;
    end
  end else begin : g_many
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sr <= '0;
      else        sr <= {sr[DEPTH-2:0], in};
    end
  end

  assign out   = sr[DEPTH-1];
  assign empty = ~|sr;

endmodule

// File: rtl/layer_transfer_sequencer.sv
// Streams COUNT words from a layer output buffer into the next layer.
// Define LAYER_SEQ_TIMEOUT_EN to enable the sink-completion watchdog.
module layer_transfer_sequencer
  import encoder_pkg::*;
#(
  parameter int COUNT          = 169,
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = encoder_pkg::DATA_W,
  parameter int RD_LAT         = 2,
  parameter int TIMEOUT_CYCLES = 65535
)(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  layer_transfer_sequencer_if.master bus
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("RD_LAT must be 1..4");
  end
  if (COUNT < 1 || (COUNT - 1) >= (1 << ADDR_W)) begin : g_bad_cnt
    $error("COUNT-1 must fit in ADDR_W");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be positive");
  end
  if (encoder_pkg::INT_W + encoder_pkg::FRAC_W
      != encoder_pkg::DATA_W) begin : g_bad_q
    $error("Q format mismatch");
  end

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COUNT - 1);

  seq_state_t        state;
  seq_state_t        state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_n;
  logic              en_q;
  logic              en_n;
  logic [DATA_W-1:0] data_q;
  logic              vld_q;
  logic              line_out;
  logic              line_empty;
  logic              wd_hit;

  valid_delay_line #(
    .DEPTH(RD_LAT)
  ) u_vline (
    .clk  (clk),
    .reset(reset),
    .in   (en_q),
    .out  (line_out),
    .empty(line_empty)
  );

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == ST_WAIT_SINK && !bus.snk_done) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign err = (state == ST_ERROR);
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    en_n    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_n = ST_READ;
          addr_n  = '0;
          en_n    = 1'b1;
        end
      end
      ST_READ: begin
        if (addr_q == LAST) begin
          state_n = ST_DRAIN;
          addr_n  = '0;
        end else begin
          addr_n  = addr_q + 1'b1;
          en_n    = 1'b1;
        end
      end
      // last beat is out once the line is empty and snk_valid has dropped
      ST_DRAIN: begin
        if (line_empty && !vld_q) begin
          state_n = ST_WAIT_SINK;
        end
      end
      ST_WAIT_SINK: begin
        if (bus.snk_done) begin
          state_n = ST_DONE;
        end else if (wd_hit) begin
          state_n = ST_ERROR;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      en_q   <= 1'b0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      en_q   <= en_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= bus.src_data;
      vld_q  <= line_out;
    end
  end

  assign bus.src_addr  = addr_q;
  assign bus.src_en    = en_q;
  assign bus.snk_data  = data_q;
  assign bus.snk_valid = vld_q;

  assign busy = is_busy(state);
  assign done = (state == ST_DONE);

endmodule
